// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - host-side SPI master for the 16-bit address/rw/data memory frame
//
// Accepts a single-cycle command and shifts out {addr[6:0], rw, wdata[7:0]} MSB first,
// capturing the last 8 miso bits into o_rdata on reads.
//
// Ports:
//   i_clk       system clock, all logic on rising edge
//   i_reset     synchronous active-high reset
//   i_start     command strobe, sampled only while idle
//   i_rw        1 = read, 0 = write
//   i_addr      7-bit memory address
//   i_wdata     8-bit write data (ignored on reads)
//   o_busy      high from the cycle after an accepted start until the gap completes
//   o_done      one-cycle pulse in the cycle cs returns high
//   o_rdata     last read result
//   o_sclk      SPI clock, idles low
//   o_cs        chip select, active low
//   o_mosi      serial data to memory
//   i_miso      serial data from memory

module spi_master_ctrl #(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_sclk,
  output logic       o_cs,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam int HP_W  = $clog2(HALF_PERIOD + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [15:0]      r_tx;
  logic [7:0]       r_rx;
  logic [7:0]       r_rdata;
  logic [HP_W-1:0]  r_hp_cnt;
  logic [4:0]       r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_rw;
  logic             r_sclk;
  logic             r_cs;
  logic             r_busy;
  logic             r_done;

  logic             w_hp_last;

  assign w_hp_last = (r_hp_cnt == HP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 16'h0000;
      r_rx      <= 8'h00;
      r_rdata   <= 8'h00;
      r_hp_cnt  <= '0;
      r_bit_cnt <= 5'd0;
      r_gap_cnt <= '0;
      r_rw      <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Write data slot is forced to zero on reads so mosi stays low in the data phase.
            r_tx      <= {i_addr, i_rw, (i_rw ? 8'h00 : i_wdata)};
            r_rw      <= i_rw;
            r_rx      <= 8'h00;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= 5'd0;
            r_hp_cnt  <= '0;
            r_state   <= S_LEAD;
          end
        end
        S_LEAD, S_LOW: begin
          if (w_hp_last) begin
            r_hp_cnt <= '0;
            r_sclk   <= 1'b1;
            r_state  <= S_HIGH;
          end else begin
            r_hp_cnt <= r_hp_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_hp_last) begin
            r_hp_cnt  <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_rw && (r_bit_cnt >= 5'd8)) begin
              r_rx <= {r_rx[6:0], i_miso};
            end
            // Shifting in zeros means the register is empty after the 16th bit,
            // which parks mosi low through TAIL and IDLE without a separate path.
            r_tx <= {r_tx[14:0], 1'b0};
            if (r_bit_cnt == 5'd15) begin
              r_state <= S_TAIL;
            end else begin
              r_state <= S_LOW;
            end
          end else begin
            r_hp_cnt <= r_hp_cnt + 1'b1;
          end
        end
        S_TAIL: begin
          if (w_hp_last) begin
            r_hp_cnt  <= '0;
            r_cs      <= 1'b1;
            r_done    <= 1'b1;
            r_gap_cnt <= '0;
            if (r_rw) begin
              r_rdata <= r_rx;
            end
            r_state <= S_GAP;
          end else begin
            r_hp_cnt <= r_hp_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sclk  <= 1'b0;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
          r_tx    <= 16'h0000;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
  assign o_sclk  = r_sclk;
  assign o_cs    = r_cs;
  assign o_mosi  = r_tx[15];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl

module tb_spi_master_ctrl;

  localparam int HP  = 50;
  localparam int GAP = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       miso = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rdata;
  logic       o_sclk;
  logic       o_cs;
  logic       o_mosi;

  always #5 clk = ~clk;

  spi_master_ctrl #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_rw    (rw),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_rdata (o_rdata),
    .o_sclk  (o_sclk),
    .o_cs    (o_cs),
    .o_mosi  (o_mosi),
    .i_miso  (miso)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pin monitor, sampled on the falling clk edge.
  int          rises       = 0;
  int          dones       = 0;
  int          mosi_viol   = 0;
  int          bad_frames  = 0;
  int          short_gaps  = 0;
  int          cur_low     = 0;
  int          cur_high    = 0;
  int          last_low    = 0;
  int          frame_rises = 0;
  logic [15:0] mosi_cap    = 16'h0000;
  logic        p_sclk      = 1'b0;
  logic        p_mosi      = 1'b0;
  logic        p_cs        = 1'b1;

  always @(negedge clk) begin
    if (!o_cs && p_cs) begin
      if (cur_high < GAP) short_gaps++;
      cur_low  = 0;
      mosi_cap = 16'h0000;
    end
    if (o_cs && !p_cs) begin
      last_low = cur_low;
      if (frame_rises != 16) bad_frames++;
      frame_rises = 0;
      cur_high    = 0;
    end
    if (o_sclk && !p_sclk) begin
      rises++;
      frame_rises++;
      mosi_cap = {mosi_cap[14:0], o_mosi};
      if (o_mosi !== p_mosi) mosi_viol++;
    end
    if (o_sclk && p_sclk && (o_mosi !== p_mosi)) mosi_viol++;
    if (o_cs) cur_high++;
    else cur_low++;
    if (o_done) dones++;
    p_sclk = o_sclk;
    p_mosi = o_mosi;
    p_cs   = o_cs;
  end

  // Behavioural SPI memory: address 7'h33 always returns 8'hA3.
  logic [7:0]  mem [0:127];
  int          s_k    = 0;
  logic [15:0] s_sh   = 16'h0000;
  logic [6:0]  s_addr = 7'h00;
  logic        s_rw   = 1'b0;
  logic [7:0]  s_rd   = 8'h00;

  always @(posedge o_sclk or posedge o_cs) begin
    if (o_cs) begin
      s_k  = 0;
      miso = 1'b0;
    end else begin
      s_sh = {s_sh[14:0], o_mosi};
      if (s_k == 7) begin
        s_addr = s_sh[7:1];
        s_rw   = s_sh[0];
        s_rd   = (s_sh[7:1] == 7'h33) ? 8'hA3 : mem[s_sh[7:1]];
      end
      if (s_k >= 8 && s_rw) miso = s_rd[15 - s_k];
      if (s_k == 15 && !s_rw) mem[s_addr] = s_sh[7:0];
      s_k++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, (n < 4000)}, 32'd1);
  endtask

  task automatic frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] exp_mosi, input logic [7:0] exp_rdata, input string tag);
    int r0;
    int d0;
    r0 = rises;
    d0 = dones;
    start = 1'b1;
    rw    = r;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    chk({tag, "_cs_low"}, {31'd0, o_cs}, 32'd0);
    chk({tag, "_first_mosi"}, {31'd0, o_mosi}, {31'd0, a[6]});
    wait_idle();
    chk({tag, "_rises"}, rises - r0, 32'd16);
    chk({tag, "_done_pulses"}, dones - d0, 32'd1);
    chk({tag, "_mosi_bits"}, {16'd0, mosi_cap}, {16'd0, exp_mosi});
    chk({tag, "_cs_low_len"}, last_low, 33 * HP);
    chk({tag, "_rdata"}, {24'd0, o_rdata}, {24'd0, exp_rdata});
  endtask

  initial begin
    int r0;
    int d0;
    int b0;
    int g0;
    int n;

    reset = 1'b1;
    start = 1'b0;
    rw    = 1'b0;
    addr  = 7'h00;
    wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    chk("rst_cs",    {31'd0, o_cs},    32'd1);
    chk("rst_sclk",  {31'd0, o_sclk},  32'd0);
    chk("rst_mosi",  {31'd0, o_mosi},  32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    chk("rst_rdata", {24'd0, o_rdata}, 32'h00);

    frame(1'b0, 7'h01, 8'h55, 16'h0255, 8'h00, "wr01_55");
    frame(1'b1, 7'h01, 8'h00, 16'h0300, 8'h55, "rd01_55");
    frame(1'b0, 7'h01, 8'h00, 16'h0200, 8'h55, "wr01_00");
    frame(1'b1, 7'h01, 8'h00, 16'h0300, 8'h00, "rd01_00");
    frame(1'b1, 7'h33, 8'hFF, 16'h6700, 8'hA3, "rd33_a3");

    // Start held high: each accepted frame is 1 + 1650 + 100 cycles, so 3 fit in 5000.
    r0 = rises;
    d0 = dones;
    b0 = bad_frames;
    g0 = short_gaps;
    rw    = 1'b0;
    addr  = 7'h10;
    wdata = 8'h3C;
    start = 1'b1;
    repeat (5000) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("hammer_dones",      dones - d0,      32'd3);
    chk("hammer_rises",      rises - r0,      32'd48);
    chk("hammer_bad_frames", bad_frames - b0, 32'd0);
    chk("hammer_short_gaps", short_gaps - g0, 32'd0);
    chk("hammer_rdata_kept", {24'd0, o_rdata}, 32'hA3);

    // Abort a read at the ninth sclk rise.
    r0 = rises;
    rw    = 1'b1;
    addr  = 7'h01;
    wdata = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((rises - r0) < 9 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rise9_timeout", {31'd0, (n < 2000)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cs",    {31'd0, o_cs},    32'd1);
    chk("abort_sclk",  {31'd0, o_sclk},  32'd0);
    chk("abort_busy",  {31'd0, o_busy},  32'd0);
    chk("abort_done",  {31'd0, o_done},  32'd0);
    chk("abort_mosi",  {31'd0, o_mosi},  32'd0);
    chk("abort_rdata", {24'd0, o_rdata}, 32'h00);
    repeat (5) @(negedge clk);

    frame(1'b0, 7'h05, 8'hC3, 16'h0AC3, 8'h00, "wr05_c3");
    frame(1'b1, 7'h05, 8'h00, 16'h0B00, 8'hC3, "rd05_c3");

    chk("mosi_invariant", mosi_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
